// File: rtl/tcp_open_retry_ctrl.sv
// ---------------------------------------------------------------------------
// tcp_open_retry_ctrl : forwards one TCP open request to the TOE, retrying
// on failure/timeout with a fixed back-off; returns one result word. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tcp_open_retry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'h0EE6_B280,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned BACKOFF_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  input  logic [47:0] s_req_data,
  output logic        m_toe_open_valid,
  input  logic        m_toe_open_ready,
  output logic [47:0] m_toe_open_data,
  input  logic        s_toe_status_valid,
  output logic        s_toe_status_ready,
  input  logic [23:0] s_toe_status_data,
  output logic        m_result_valid,
  input  logic        m_result_ready,
  output logic [31:0] m_result_data,
  output logic        busy,
  output logic [31:0] stat_attempts,
  output logic [31:0] stat_timeouts,
  output logic [31:0] stat_stray
);

  localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] BACKOFF_LAST = 32'(BACKOFF_CYCLES - 1);
  localparam logic [3:0]  MAX_ATT      = 4'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_REPORT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] open_data_q, open_data_d;
  logic [31:0] result_q, result_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  attempt_q, attempt_d;
  logic [31:0] stat_attempts_q, stat_attempts_d;
  logic [31:0] stat_timeouts_q, stat_timeouts_d;
  logic [31:0] stat_stray_q, stat_stray_d;

  logic        fail;
  logic        fail_tmo;

  // Upper status bits carry nothing for this block.
  logic unused_status_hi;
  assign unused_status_hi = ^s_toe_status_data[23:17];

  always_comb begin
    state_d         = state_q;
    open_data_d     = open_data_q;
    result_d        = result_q;
    timer_d         = timer_q;
    attempt_d       = attempt_q;
    stat_attempts_d = stat_attempts_q;
    stat_timeouts_d = stat_timeouts_q;
    stat_stray_d    = stat_stray_q;
    fail            = 1'b0;
    fail_tmo        = 1'b0;

    if (s_toe_status_valid && (state_q != ST_WAIT)) begin
      stat_stray_d = stat_stray_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_req_valid) begin
          open_data_d = s_req_data;
          attempt_d   = 4'd0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_toe_open_ready) begin
          attempt_d       = attempt_q + 4'd1;
          stat_attempts_d = stat_attempts_q + 32'd1;
          timer_d         = 32'd0;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 32'd1;
        // A status beat takes priority over a coincident expiry.
        if (s_toe_status_valid) begin
          if (s_toe_status_data[16]) begin
            result_d = {8'h00, attempt_q, 2'b00, 1'b0, 1'b1, s_toe_status_data[15:0]};
            state_d  = ST_REPORT;
          end else begin
            fail = 1'b1;
          end
        end else if (timer_q == TMO_LAST) begin
          fail            = 1'b1;
          fail_tmo        = 1'b1;
          stat_timeouts_d = stat_timeouts_q + 32'd1;
        end
        if (fail) begin
          if (attempt_q < MAX_ATT) begin
            timer_d = 32'd0;
            state_d = ST_BACKOFF;
          end else begin
            result_d = {8'h00, attempt_q, 2'b00, fail_tmo, 1'b0, 16'h0000};
            state_d  = ST_REPORT;
          end
        end
      end
      ST_BACKOFF: begin
        if (timer_q == BACKOFF_LAST) begin
          state_d = ST_SEND;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_REPORT: begin
        if (m_result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      open_data_q     <= 48'd0;
      result_q        <= 32'd0;
      timer_q         <= 32'd0;
      attempt_q       <= 4'd0;
      stat_attempts_q <= 32'd0;
      stat_timeouts_q <= 32'd0;
      stat_stray_q    <= 32'd0;
    end else begin
      state_q         <= state_d;
      open_data_q     <= open_data_d;
      result_q        <= result_d;
      timer_q         <= timer_d;
      attempt_q       <= attempt_d;
      stat_attempts_q <= stat_attempts_d;
      stat_timeouts_q <= stat_timeouts_d;
      stat_stray_q    <= stat_stray_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign s_req_ready        = (state_q == ST_IDLE);
  assign m_toe_open_valid   = (state_q == ST_SEND);
  assign m_result_valid     = (state_q == ST_REPORT);
  assign busy               = (state_q != ST_IDLE);
  assign s_toe_status_ready = 1'b1;
  assign m_toe_open_data    = open_data_q;
  assign m_result_data      = result_q;
  assign stat_attempts      = stat_attempts_q;
  assign stat_timeouts      = stat_timeouts_q;
  assign stat_stray         = stat_stray_q;

endmodule

`default_nettype wire

// File: tb/tb_tcp_open_retry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tcp_open_retry_ctrl : directed self-checking bench for tcp_open_retry_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tcp_open_retry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_req_valid;
  logic        s_req_ready;
  logic [47:0] s_req_data;
  logic        m_toe_open_valid;
  logic        m_toe_open_ready;
  logic [47:0] m_toe_open_data;
  logic        s_toe_status_valid;
  logic        s_toe_status_ready;
  logic [23:0] s_toe_status_data;
  logic        m_result_valid;
  logic        m_result_ready;
  logic [31:0] m_result_data;
  logic        busy;
  logic [31:0] stat_attempts;
  logic [31:0] stat_timeouts;
  logic [31:0] stat_stray;

  int errors = 0;
  int checks = 0;
  int n_open = 0;
  int n_result = 0;

  always #5 clk = ~clk;

  tcp_open_retry_ctrl #(
    .TIMEOUT_CYCLES(100),
    .MAX_ATTEMPTS  (3),
    .BACKOFF_CYCLES(8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_req_valid       (s_req_valid),
    .s_req_ready       (s_req_ready),
    .s_req_data        (s_req_data),
    .m_toe_open_valid  (m_toe_open_valid),
    .m_toe_open_ready  (m_toe_open_ready),
    .m_toe_open_data   (m_toe_open_data),
    .s_toe_status_valid(s_toe_status_valid),
    .s_toe_status_ready(s_toe_status_ready),
    .s_toe_status_data (s_toe_status_data),
    .m_result_valid    (m_result_valid),
    .m_result_ready    (m_result_ready),
    .m_result_data     (m_result_data),
    .busy              (busy),
    .stat_attempts     (stat_attempts),
    .stat_timeouts     (stat_timeouts),
    .stat_stray        (stat_stray)
  );

  // Observed handshakes on the two output channels.
  always @(posedge clk) begin
    if (!rst && m_toe_open_valid && m_toe_open_ready) n_open <= n_open + 1;
    if (!rst && m_result_valid && m_result_ready) n_result <= n_result + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_req_valid = 1'b0;
    s_req_data = 48'd0;
    m_toe_open_ready = 1'b1;
    s_toe_status_valid = 1'b0;
    s_toe_status_data = 24'd0;
    m_result_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_req(input logic [47:0] d);
    s_req_valid = 1'b1;
    s_req_data = d;
    tick();
    s_req_valid = 1'b0;
  endtask

  task automatic status_beat(input logic [23:0] d);
    s_toe_status_valid = 1'b1;
    s_toe_status_data = d;
    tick();
    s_toe_status_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_req_valid = 1'b1;
    s_req_data = 48'hFFFF_FFFF_FFFF;
    m_toe_open_ready = 1'b1;
    s_toe_status_valid = 1'b0;
    s_toe_status_data = 24'd0;
    m_result_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({m_toe_open_valid, m_result_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids: got %b, expected 000", {m_toe_open_valid, m_result_valid, busy});
    end
    checks++;
    if (m_toe_open_data !== 48'd0) begin
      errors++;
      $display("FAIL reset_open_data: got %h, expected 0", m_toe_open_data);
    end
    checks++;
    if (m_result_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_result_data: got %h, expected 0", m_result_data);
    end
    checks++;
    if ({stat_attempts, stat_timeouts, stat_stray} !== 96'd0) begin
      errors++;
      $display("FAIL reset_stats: got %h %h %h, expected 0", stat_attempts, stat_timeouts, stat_stray);
    end
    checks++;
    if ({s_req_ready, s_toe_status_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_readies: got %b, expected 11", {s_req_ready, s_toe_status_ready});
    end
    rst = 1'b0;
    s_req_valid = 1'b0;
  endtask

  task automatic test_basic_success();
    int base;
    do_reset();
    base = n_open;
    send_req(48'h1F90_0A00_0102);
    checks++;
    if (m_toe_open_valid !== 1'b1 || m_toe_open_data !== 48'h1F90_0A00_0102) begin
      errors++;
      $display("FAIL basic_open: got valid=%b data=%h, expected 1 1f900a000102", m_toe_open_valid, m_toe_open_data);
    end
    tick();
    checks++;
    if (m_toe_open_valid !== 1'b0 || busy !== 1'b1 || stat_attempts !== 32'd1) begin
      errors++;
      $display("FAIL basic_wait: got valid=%b busy=%b att=%0d, expected 0 1 1", m_toe_open_valid, busy, stat_attempts);
    end
    repeat (9) tick();
    status_beat(24'h01_0005);
    checks++;
    if (m_result_valid !== 1'b1 || m_result_data !== 32'h0011_0005) begin
      errors++;
      $display("FAIL basic_result: got valid=%b data=%h, expected 1 00110005", m_result_valid, m_result_data);
    end
    tick();
    checks++;
    if (m_result_valid !== 1'b1 || m_result_data !== 32'h0011_0005) begin
      errors++;
      $display("FAIL basic_result_hold: got valid=%b data=%h, expected 1 00110005", m_result_valid, m_result_data);
    end
    m_result_ready = 1'b1;
    tick();
    m_result_ready = 1'b0;
    checks++;
    if (m_result_valid !== 1'b0 || s_req_ready !== 1'b1 || (n_open - base) !== 1 || stat_attempts !== 32'd1) begin
      errors++;
      $display("FAIL basic_done: got rv=%b rdy=%b opens=%0d att=%0d, expected 0 1 1 1", m_result_valid, s_req_ready, n_open - base, stat_attempts);
    end
  endtask

  task automatic test_fail_then_succeed();
    int base;
    int n;
    do_reset();
    base = n_open;
    send_req(48'hABCD_C0A8_0001);
    tick();
    repeat (4) tick();
    status_beat(24'h00_1234);
    n = 0;
    while (!m_toe_open_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 8 || m_toe_open_data !== 48'hABCD_C0A8_0001) begin
      errors++;
      $display("FAIL retry_gap: got %0d cycles data=%h, expected 8 abcdc0a80001", n, m_toe_open_data);
    end
    tick();
    repeat (2) tick();
    status_beat(24'h01_0007);
    checks++;
    if (m_result_valid !== 1'b1 || m_result_data !== 32'h0021_0007) begin
      errors++;
      $display("FAIL retry_result: got valid=%b data=%h, expected 1 00210007", m_result_valid, m_result_data);
    end
    m_result_ready = 1'b1;
    tick();
    m_result_ready = 1'b0;
    checks++;
    if (stat_attempts !== 32'd2 || stat_timeouts !== 32'd0 || (n_open - base) !== 2) begin
      errors++;
      $display("FAIL retry_stats: got att=%0d tmo=%0d opens=%0d, expected 2 0 2", stat_attempts, stat_timeouts, n_open - base);
    end
  endtask

  task automatic test_all_timeouts();
    int base;
    int n;
    logic [31:0] t99;
    logic [31:0] t100;
    do_reset();
    base = n_open;
    send_req(48'h0050_0A0A_0A0A);
    tick();
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      t99 = 32'hDEAD;
      t100 = 32'hDEAD;
      while (n < 300) begin
        tick();
        n++;
        if (n == 99) t99 = stat_timeouts;
        if (n == 100) t100 = stat_timeouts;
        if ((k < 3) ? m_toe_open_valid : m_result_valid) break;
      end
      checks++;
      if (n !== ((k < 3) ? 108 : 100) || t99 !== 32'(k - 1) || t100 !== 32'(k)) begin
        errors++;
        $display("FAIL timeout_attempt%0d: got span=%0d tmo99=%0d tmo100=%0d, expected %0d %0d %0d",
                 k, n, t99, t100, (k < 3) ? 108 : 100, k - 1, k);
      end
      if (k < 3) tick();
    end
    checks++;
    if (m_result_data !== 32'h0032_0000 || stat_timeouts !== 32'd3 || stat_attempts !== 32'd3 || (n_open - base) !== 3) begin
      errors++;
      $display("FAIL timeout_result: got data=%h tmo=%0d att=%0d opens=%0d, expected 00320000 3 3 3",
               m_result_data, stat_timeouts, stat_attempts, n_open - base);
    end
    m_result_ready = 1'b1;
    tick();
    m_result_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_req(48'h0016_0A00_0003);
    tick();
    repeat (99) tick();
    status_beat(24'h01_00AB);
    checks++;
    if (m_result_valid !== 1'b1 || m_result_data !== 32'h0011_00AB || stat_timeouts !== 32'd0) begin
      errors++;
      $display("FAIL simultaneous: got valid=%b data=%h tmo=%0d, expected 1 001100ab 0", m_result_valid, m_result_data, stat_timeouts);
    end
    m_result_ready = 1'b1;
    tick();
    m_result_ready = 1'b0;
  endtask

  task automatic test_backpressure_stray();
    int bad;
    int n;
    do_reset();
    m_toe_open_ready = 1'b0;
    status_beat(24'h01_9999);
    checks++;
    if (stat_stray !== 32'd1 || busy !== 1'b0 || s_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_idle: got stray=%0d busy=%b rdy=%b, expected 1 0 1", stat_stray, busy, s_req_ready);
    end
    s_req_valid = 1'b1;
    s_req_data = 48'h1111_2222_3333;
    tick();
    s_req_data = 48'h4444_5555_6666;
    bad = 0;
    repeat (50) begin
      if (!(m_toe_open_valid === 1'b1 && m_toe_open_data === 48'h1111_2222_3333 && s_req_ready === 1'b0)) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || stat_attempts !== 32'd0) begin
      errors++;
      $display("FAIL open_backpressure: got bad_cycles=%0d att=%0d, expected 0 0", bad, stat_attempts);
    end
    s_req_valid = 1'b0;
    m_toe_open_ready = 1'b1;
    tick();
    status_beat(24'h00_0000);
    n = 0;
    tick();
    tick();
    n = 2;
    status_beat(24'h01_0042);
    n++;
    checks++;
    if (stat_stray !== 32'd2) begin
      errors++;
      $display("FAIL stray_backoff: got %0d, expected 2", stat_stray);
    end
    while (!m_toe_open_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 8 || stat_attempts !== 32'd1) begin
      errors++;
      $display("FAIL stray_gap: got %0d cycles att=%0d, expected 8 1", n, stat_attempts);
    end
    tick();
    status_beat(24'h01_0033);
    s_req_valid = 1'b1;
    s_req_data = 48'h7777_8888_9999;
    bad = 0;
    repeat (20) begin
      if (!(m_result_valid === 1'b1 && m_result_data === 32'h0021_0033 && s_req_ready === 1'b0)) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL result_backpressure: got bad_cycles=%0d, expected 0", bad);
    end
    s_req_valid = 1'b0;
    m_result_ready = 1'b1;
    tick();
    m_result_ready = 1'b0;
    checks++;
    if (m_result_valid !== 1'b0 || s_req_ready !== 1'b1 || stat_stray !== 32'd2) begin
      errors++;
      $display("FAIL backpressure_done: got rv=%b rdy=%b stray=%0d, expected 0 1 2", m_result_valid, s_req_ready, stat_stray);
    end
  endtask

  task automatic test_reset_mid_wait();
    int base_res;
    base_res = n_result;
    send_req(48'h0BB8_0A00_0009);
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_req_valid = 1'b1;
    s_req_data = 48'h0BB9_0A00_000A;
    checks++;
    if ({m_toe_open_valid, m_result_valid, busy} !== 3'b000 || m_toe_open_data !== 48'd0 || m_result_data !== 32'd0
        || {stat_attempts, stat_timeouts, stat_stray} !== 96'd0) begin
      errors++;
      $display("FAIL rst_mid_wait_outputs: got v=%b od=%h rd=%h st=%h/%h/%h, expected all 0",
               {m_toe_open_valid, m_result_valid, busy}, m_toe_open_data, m_result_data, stat_attempts, stat_timeouts, stat_stray);
    end
    tick();
    s_req_valid = 1'b0;
    checks++;
    if (m_toe_open_valid !== 1'b1 || m_toe_open_data !== 48'h0BB9_0A00_000A || n_result !== base_res) begin
      errors++;
      $display("FAIL rst_mid_wait_new_req: got valid=%b data=%h results=%0d, expected 1 0bb90a00000a %0d",
               m_toe_open_valid, m_toe_open_data, n_result - base_res, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_success();
    test_fail_then_succeed();
    test_all_timeouts();
    test_simultaneous();
    test_backpressure_stray();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
